// File: rtl/manchester_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_pkg
//  Description : Shared definitions for the Manchester frame transmitter and
//                its matching decoder: FSM states, SFD pattern, preamble
//                start bit and IEEE 802.3 line polarity constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package manchester_pkg;

  // Frame sequencer states (PARITY is reachable only in parity builds)
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_PARITY   = 3'd4,
    ST_GAP      = 3'd5
  } state_t;

  // Start-of-frame delimiter, sent MSB first
  localparam logic [1:0] SFD_BITS = 2'b11;

  // Preamble alternates starting from this value
  localparam logic PREAMBLE_START_BIT = 1'b1;

  // IEEE 802.3 polarity: a 1 is low-then-high, a 0 is high-then-low
  localparam logic BIT1_FIRST_HALF  = 1'b0;
  localparam logic BIT1_SECOND_HALF = 1'b1;
  localparam logic BIT0_FIRST_HALF  = 1'b1;
  localparam logic BIT0_SECOND_HALF = 1'b0;

  // Line level outside of a frame
  localparam logic LINE_IDLE = 1'b0;

  // Line level for one half of an encoded bit
  function automatic logic encode_half(input logic bit_val, input logic second_half);
    if (second_half) return bit_val ? BIT1_SECOND_HALF : BIT0_SECOND_HALF;
    else             return bit_val ? BIT1_FIRST_HALF  : BIT0_FIRST_HALF;
  endfunction

endpackage
`default_nettype wire

// File: rtl/manchester_halfbit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_halfbit_timer
//  Description : Emits a one-cycle strobe on the last cycle of every
//                half-bit (every HALF_BIT_CYC cycles) while enabled. The
//                count restarts from zero whenever the timer is disabled.
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_halfbit_timer #(
  parameter int HALF_BIT_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic strobe
);

  generate
    if (HALF_BIT_CYC == 1) begin : g_single
      // Every enabled cycle is a complete half-bit; no counter needed
      wire unused_clk_rst = &{1'b0, clk, rst};
      assign strobe = en;
    end else begin : g_count
      localparam int CW = $clog2(HALF_BIT_CYC);
      localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CYC - 1);

      logic [CW-1:0] count;

      // Position within the current half-bit, wrapping at LAST
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                count <= '0;
        else if (!en)           count <= '0;
        else if (count == LAST) count <= '0;
        else                    count <= count + 1'b1;
      end

      assign strobe = en && (count == LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/manchester_frame_tx.sv
`default_nettype none
// ============================================================================
//  Module      : manchester_frame_tx
//  Description : Manchester (IEEE 802.3) frame transmitter. Accepts a payload
//                on a valid/ready handshake and sends preamble, SFD, payload
//                (MSB first), optional even parity, then an idle gap.
//                Optional feature macro: MANCHESTER_TX_PARITY_EN adds a
//                parity bit after the payload.
//  Revision    : 1.0 - initial release
// ============================================================================
module manchester_frame_tx
  import manchester_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int HALF_BIT_CYC = 4,
  parameter int PREAMBLE_LEN = 8,
  parameter int GAP_BITS     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              manchester_out,
  output logic              tx_active
);

  // One bit counter serves every state; size it for the longest one
  localparam int MAX_A   = (PREAMBLE_LEN > DATA_W) ? PREAMBLE_LEN : DATA_W;
  localparam int MAX_B   = (MAX_A > GAP_BITS) ? MAX_A : GAP_BITS;
  localparam int MAX_CNT = (MAX_B > 2) ? MAX_B : 2;
  localparam int CNT_W   = $clog2(MAX_CNT);

  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PREAMBLE_LEN - 1);
  localparam logic [CNT_W-1:0] SFD_LAST  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  // With no gap the last payload bit returns straight to IDLE
  localparam state_t AFTER_PAYLOAD = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
`ifdef MANCHESTER_TX_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
`else
  localparam state_t AFTER_DATA = AFTER_PAYLOAD;
`endif

  state_t             state, state_n;
  logic               half, half_n;          // 0 = first half, 1 = second half
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [DATA_W-1:0]  shreg, shreg_n;
  logic               line_n, active_n;
  logic               tx_bit;
  logic               on_air;
  logic               half_strobe;
`ifdef MANCHESTER_TX_PARITY_EN
  logic               parity_q, parity_n;
`endif

  assign in_ready = (state == ST_IDLE);

  manchester_halfbit_timer #(
    .HALF_BIT_CYC (HALF_BIT_CYC)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state != ST_IDLE),
    .strobe (half_strobe)
  );

  // Sequencer registers and the registered line output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_IDLE;
      half           <= 1'b0;
      bit_cnt        <= '0;
      shreg          <= '0;
      manchester_out <= LINE_IDLE;
      tx_active      <= 1'b0;
`ifdef MANCHESTER_TX_PARITY_EN
      parity_q       <= 1'b0;
`endif
    end else begin
      state          <= state_n;
      half           <= half_n;
      bit_cnt        <= bit_cnt_n;
      shreg          <= shreg_n;
      manchester_out <= line_n;
      tx_active      <= active_n;
`ifdef MANCHESTER_TX_PARITY_EN
      parity_q       <= parity_n;
`endif
    end
  end

  // Next-state and next-line logic; line is computed from the next state so
  // the first preamble half appears right after the transfer edge
  always_comb begin
    state_n   = state;
    half_n    = half;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
`ifdef MANCHESTER_TX_PARITY_EN
    parity_n  = parity_q;
`endif

    if (state == ST_IDLE) begin
      if (in_valid) begin
        state_n   = ST_PREAMBLE;
        half_n    = 1'b0;
        bit_cnt_n = '0;
        shreg_n   = in_data;
`ifdef MANCHESTER_TX_PARITY_EN
        parity_n  = ^in_data;
`endif
      end
    end else if (half_strobe) begin
      half_n = ~half;
      if (half) begin
        bit_cnt_n = bit_cnt + 1'b1;
        case (state)
          ST_PREAMBLE: if (bit_cnt == PRE_LAST) begin
            state_n   = ST_SFD;
            bit_cnt_n = '0;
          end
          ST_SFD: if (bit_cnt == SFD_LAST) begin
            state_n   = ST_DATA;
            bit_cnt_n = '0;
          end
          ST_DATA: begin
            shreg_n = shreg << 1;
            if (bit_cnt == DATA_LAST) begin
              state_n   = AFTER_DATA;
              bit_cnt_n = '0;
            end
          end
`ifdef MANCHESTER_TX_PARITY_EN
          ST_PARITY: begin
            state_n   = AFTER_PAYLOAD;
            bit_cnt_n = '0;
          end
`endif
          ST_GAP: if (bit_cnt == GAP_LAST) begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
          end
          default: begin
            state_n   = ST_IDLE;
            bit_cnt_n = '0;
          end
        endcase
      end
    end

    tx_bit = 1'b0;
    on_air = 1'b0;
    case (state_n)
      ST_PREAMBLE: begin
        tx_bit = PREAMBLE_START_BIT ^ bit_cnt_n[0];
        on_air = 1'b1;
      end
      ST_SFD: begin
        tx_bit = bit_cnt_n[0] ? SFD_BITS[0] : SFD_BITS[1];
        on_air = 1'b1;
      end
      ST_DATA: begin
        tx_bit = shreg_n[DATA_W-1];
        on_air = 1'b1;
      end
`ifdef MANCHESTER_TX_PARITY_EN
      ST_PARITY: begin
        tx_bit = parity_n;
        on_air = 1'b1;
      end
`endif
      default: begin
        tx_bit = 1'b0;
        on_air = 1'b0;
      end
    endcase

    line_n   = on_air ? encode_half(tx_bit, half_n) : LINE_IDLE;
    active_n = on_air;
  end

endmodule
`default_nettype wire

// File: doc/manchester_frame_tx.md
MANCHESTER_FRAME_TX -- requirements
Module: manchester_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload bits per frame.
REQ-002 Parameter HALF_BIT_CYC, default 4: clk cycles per Manchester half-bit; legal range is 1 or more.
REQ-003 Parameter PREAMBLE_LEN, default 8: preamble bits per frame; legal range is 2 or more and even.
REQ-004 Parameter GAP_BITS, default 2: idle bit periods after each frame; legal range is 0 or more.
REQ-005 clk input, 1 bit: clock, rising edge.
REQ-006 rst input, 1 bit: reset, asynchronous, active-high.
REQ-007 in_valid input, 1 bit: payload offered.
REQ-008 in_data input, DATA_W bits: payload; sampled only on transfer.
REQ-009 in_ready output, 1 bit: block can accept a payload.
REQ-010 manchester_out output, 1 bit: encoded line, registered.
REQ-011 tx_active output, 1 bit: high from the first preamble half-bit through the last data or parity half-bit.

Function
REQ-012 A transfer SHALL occur on a rising clk edge with in_valid=1 and in_ready=1; in_data is latched into the shift register at that edge.
REQ-013 in_ready SHALL be high only in IDLE; it drops in the cycle after the transfer edge.
REQ-014 Encoding SHALL follow IEEE 802.3: bit 1 = low half then high half; bit 0 = high half then low half.
REQ-015 Each half-bit SHALL last exactly HALF_BIT_CYC cycles; a bit period is 2*HALF_BIT_CYC cycles.
REQ-016 The first half-bit of the frame SHALL appear on manchester_out in the cycle after the transfer edge, with no idle cycle inserted.
REQ-017 FSM states: IDLE -> PREAMBLE -> SFD -> DATA -> [PARITY] -> GAP -> IDLE; each transition occurs at the end of the last half-bit of the state.
REQ-018 PREAMBLE SHALL send PREAMBLE_LEN bits alternating 1,0,1,0, starting with 1.
REQ-019 SFD SHALL send the two bits 1,1.
REQ-020 DATA SHALL send DATA_W bits, MSB first.
REQ-021 GAP SHALL hold manchester_out=0 for GAP_BITS*2*HALF_BIT_CYC cycles; with GAP_BITS=0, the FSM goes directly to IDLE.
REQ-022 In IDLE, manchester_out SHALL be 0.
REQ-023 in_valid asserted during a frame SHALL be ignored; the payload is held by the source until in_ready returns high.
REQ-024 Back-to-back payloads SHALL be separated by exactly the GAP period plus one IDLE cycle for the transfer.
REQ-025 Total cycles from the transfer edge to in_ready=1 SHALL be (PREAMBLE_LEN+2+DATA_W+P+GAP_BITS)*2*HALF_BIT_CYC + 1, where P=1 when parity is enabled and 0 otherwise.
REQ-026 The half-bit counter SHALL wrap from HALF_BIT_CYC-1 to 0, and bit counters SHALL reload at every state entry.

Reset
REQ-027 rst=1 SHALL immediately force the state to IDLE, manchester_out=0, tx_active=0, in_ready=1, and clear all counters and the shift register.
REQ-028 rst asserted mid-frame SHALL abort the frame with no residual output; the aborted payload is discarded.
REQ-029 Transfers SHALL be ignored while rst=1; the first transfer is accepted on the first clk edge after rst deasserts.

Configuration
REQ-030 Macro MANCHESTER_TX_PARITY_EN defined: PARITY state sends one even-parity bit (XOR of all DATA_W payload bits) after DATA.
REQ-031 Macro MANCHESTER_TX_PARITY_EN undefined: no PARITY state and no parity logic; DATA goes directly to GAP.

Structure
REQ-032 Shared package manchester_pkg SHALL hold the FSM state enum, the SFD constant (2'b11), the preamble start bit, and the encoding polarity constants; the decoder side reuses it.
REQ-033 Sub-module manchester_halfbit_timer SHALL be the only sub-module; it generates a one-cycle half-bit-end strobe every HALF_BIT_CYC cycles while enabled.

Verification (DATA_W=8, HALF_BIT_CYC=2, PREAMBLE_LEN=4, GAP_BITS=1, parity off unless stated)
REQ-034 Send 0xA5 -> line shows preamble 1010, SFD 11, data 10100101, each bit as 2 cycles per half; in_ready returns 61 cycles after the transfer edge.
REQ-035 Send 0x00, then 0xFF with in_valid held high -> second transfer occurs exactly 61 cycles after the first; data bits are all high-low, then all low-high.
REQ-036 Pulse rst for 1 cycle at cycle 20 of a frame -> manchester_out=0 and tx_active=0 asynchronously; next transfer is accepted 1 cycle after rst deasserts.
REQ-037 Toggle in_valid and change in_data during a frame -> transmitted bits unchanged; no extra frame sent.
REQ-038 MANCHESTER_TX_PARITY_EN defined, send 0x07 -> parity bit 1 follows data; frame takes 65 cycles to in_ready.
REQ-039 HALF_BIT_CYC=1, send 0x81 -> every half-bit lasts exactly one cycle; in_ready returns 31 cycles after the transfer edge.
